cpu_register_unit: RTL and testbench
====================================

# cpu_register_unit

Integer register file of the Virgule core: `size` 32-bit general-purpose registers, two combinational read ports addressed by the source instruction, and one synchronous write port addressed by the destination instruction. Register x0 is hard-wired to zero. It sits between the decode stage, which supplies `src_instr`, and the write-back stage, which supplies `dest_instr` and `xd`.

## Interface
Parameters:
- `size`, default 32: number of architectural registers. Legal range is 2..32.

Ports:
- `clk`  input  1  clock; all writes occur on the rising edge.
- `reset`  input  1  one clock; reset is asynchronous and active-low.
- `src_instr`  input  `instruction_t`  decoded instruction being read; only its `rs1` and `rs2` fields are used.
- `dest_instr`  input  `instruction_t`  decoded instruction being retired; only its `has_rd` and `rd` fields are used.
- `enable`  input  1  write-back enable.
- `xd`  input  `word_t` (32)  data to write to `dest_instr.rd`.
- `xs1`  output  `word_t` (32)  value of register `src_instr.rs1`.
- `xs2`  output  `word_t` (32)  value of register `src_instr.rs2`.

## Operation
- Storage: registers x1..x(size-1), 32 bits each. x0 has no storage.
- Write: register x[rd] takes the value `xd` on the rising edge of `clk` when all of the following hold:
  - `reset` is high;
  - `enable` is 1;
  - `dest_instr.has_rd` is 1;
  - `dest_instr.rd` is not 0;
  - `dest_instr.rd` is less than `size`.
  In every other case the register contents are unchanged.
- Read: `xs1` equals x[`src_instr.rs1`] and `xs2` equals x[`src_instr.rs2`], combinationally.
  - An index of 0 reads 0.
  - An index at or above `size` reads 0.
- Both read ports may address the same register, and either may address the register currently being written.
- Reset: while `reset` is low, every register is cleared to 0 immediately, without waiting for a clock edge, and writes are blocked. As a result, `xs1` and `xs2` read 0 during reset.

## Timing
- Read latency: zero cycles (purely combinational from `src_instr` and stored state).
- Write latency: one edge. A value written at edge N is visible on `xs1`/`xs2` after edge N.
- Read-during-write: no bypass. During the cycle in which x[r] is being written, a read of r returns the old value; the new value appears only after the edge.
- Reset deassertion: the first possible write happens on the first rising edge at which `reset` is high.
- Assertion of `reset` in the middle of a run discards all register contents within the same cycle.

## Structure
- Shared package `virgule_pkg` provides:
  - `word_t` (32-bit logic);
  - `register_index_t` (5-bit unsigned);
  - `instruction_t` (struct with at least `rd`, `rs1`, `rs2`, `has_rd`);
  - `instr_nop`.
- Opcode constants live in `opcodes_pkg`.
- No sub-module is needed: a single module holding a register array, one always_ff block for the write port, and continuous assignments for the read ports.

## Test plan
1. Reset with `reset`=0 and all inputs toggling, rs1=5, rs2=31: `xs1`=0 and `xs2`=0; no write takes effect.
2. With `reset`=1 and `enable`=1, write x[n]=(n+1)<<12 for n=0..31 (has_rd=(n>0)). Then read pairs (0,1), (2,3) … (30,31) with `enable`=0. Required: x0 reads 0, x1 reads 0x00002000, x2 reads 0x00003000 … x31 reads 0x00020000.
3. Write to rd=0 with has_rd=1 and `xd`=0xFFFFFFFF: x0 still reads 0.
4. `enable`=0, or has_rd=0, with rd=7 and `xd`=0xDEADBEEF: x7 keeps its previous value of 0x00008000.
5. Read-during-write: rs1=rd=9 with `xd`=0x12345678. Before the edge, `xs1` shows the old value 0x0000A000; after the edge, `xs1`=0x12345678.
6. Pull `reset` low between clock edges after test 2: `xs1` and `xs2` drop to 0 immediately for every index.

Source files
------------

// File: rtl/opcodes_pkg.sv
// Virgule opcode constants.
// Major opcode encodings shared by decode and the register file bundle.
package opcodes_pkg;

   typedef logic [6:0] opcode_t;

   localparam opcode_t OP_LOAD   = 7'b0000011;
   localparam opcode_t OP_IMM    = 7'b0010011;
   localparam opcode_t OP_AUIPC  = 7'b0010111;
   localparam opcode_t OP_STORE  = 7'b0100011;
   localparam opcode_t OP_REG    = 7'b0110011;
   localparam opcode_t OP_LUI    = 7'b0110111;
   localparam opcode_t OP_BRANCH = 7'b1100011;
   localparam opcode_t OP_JALR   = 7'b1100111;
   localparam opcode_t OP_JAL    = 7'b1101111;
   localparam opcode_t OP_SYSTEM = 7'b1110011;

endpackage

// File: rtl/virgule_pkg.sv
// Virgule shared types.
// Word, register index and decoded instruction bundle.
package virgule_pkg;

   import opcodes_pkg::*;

   typedef logic [31:0] word_t;
   typedef logic [4:0]  register_index_t;

   typedef struct packed {
      opcode_t         opcode;
      register_index_t rd;
      register_index_t rs1;
      register_index_t rs2;
      logic            has_rd;
      word_t           imm;
   } instruction_t;

   localparam instruction_t instr_nop = '{
      opcode: OP_IMM,
      rd:     5'd0,
      rs1:    5'd0,
      rs2:    5'd0,
      has_rd: 1'b0,
      imm:    32'd0
   };

endpackage

// File: rtl/cpu_register_unit.sv
// Virgule integer register file.
// Two combinational read ports, one clocked write port, x0 tied to zero.
module cpu_register_unit
   import virgule_pkg::*;
#(
   parameter int size = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  instruction_t src_instr,
   input  instruction_t dest_instr,
   input  logic         enable,
   input  word_t        xd,
   output word_t        xs1,
   output word_t        xs2
);

   // x0 has no storage; entries 1..size-1 only.
   word_t regs_q [1:size-1];

   logic  wr_en;

   // Qualify the write: enabled, real destination, nonzero, in range.
   always_comb begin
      wr_en = enable
            & dest_instr.has_rd
            & (dest_instr.rd != 5'd0)
            & (int'(dest_instr.rd) < size);
   end

   // Write port; async reset wipes every register at once.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 1; i < size; i++) begin
            regs_q[i] <= '0;
         end
      end else if (wr_en) begin
         for (int i = 1; i < size; i++) begin
            if (dest_instr.rd == 5'(i)) begin
               regs_q[i] <= xd;
            end
         end
      end
   end

   // Read ports; index 0 and out-of-range indices fall through to 0.
   always_comb begin
      xs1 = '0;
      xs2 = '0;
      for (int i = 1; i < size; i++) begin
         if (src_instr.rs1 == 5'(i)) begin
            xs1 = regs_q[i];
         end
         if (src_instr.rs2 == 5'(i)) begin
            xs2 = regs_q[i];
         end
      end
   end

   // Only some instruction fields are consumed here.
   logic unused_fields;
   assign unused_fields = ^{src_instr.opcode, src_instr.rd,
                            src_instr.has_rd, src_instr.imm,
                            dest_instr.opcode, dest_instr.rs1,
                            dest_instr.rs2, dest_instr.imm};

endmodule

// File: tb/tb_cpu_register_unit.sv
// Directed bench for cpu_register_unit.
// Hand-computed expectations for reset, writes, x0 and bypass-free reads.
module tb_cpu_register_unit;

   import virgule_pkg::*;

   logic         clk;
   logic         reset;
   instruction_t src;
   instruction_t dst;
   logic         enable;
   word_t        xd;
   word_t        xs1;
   word_t        xs2;

   int errors;
   int checks;

   cpu_register_unit #(.size(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .src_instr  (src),
      .dest_instr (dst),
      .enable     (enable),
      .xd         (xd),
      .xs1        (xs1),
      .xs2        (xs2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input word_t obs,
                        input word_t exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   function automatic word_t model(input int k);
      return (k == 0) ? 32'd0 : 32'((k + 1) << 12);
   endfunction

   initial begin
      errors = 0;
      checks = 0;
      reset  = 1'b0;
      enable = 1'b0;
      xd     = '0;
      src    = instr_nop;
      dst    = instr_nop;

      // Test 1: reset held, inputs toggling, writes blocked.
      src.rs1 = 5'd5;
      src.rs2 = 5'd31;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         enable     = c[0];
         dst.has_rd = 1'b1;
         dst.rd     = (c < 2) ? 5'd5 : 5'd31;
         xd         = 32'hA5A5_0000 + 32'(c);
         #1;
         check("rst_xs1", xs1, 32'd0);
         check("rst_xs2", xs2, 32'd0);
      end
      @(negedge clk);
      enable = 1'b0;
      reset  = 1'b1;
      #1;
      check("post_rst_x5", xs1, 32'd0);
      check("post_rst_x31", xs2, 32'd0);

      // Test 2: fill every register, then read back in pairs.
      for (int n = 0; n < 32; n++) begin
         @(negedge clk);
         enable     = 1'b1;
         dst.has_rd = (n > 0);
         dst.rd     = 5'(n);
         xd         = 32'((n + 1) << 12);
      end
      @(negedge clk);
      enable = 1'b0;
      for (int p = 0; p < 16; p++) begin
         src.rs1 = 5'(2 * p);
         src.rs2 = 5'(2 * p + 1);
         #1;
         check($sformatf("rd_x%0d", 2 * p), xs1, model(2 * p));
         check($sformatf("rd_x%0d", 2 * p + 1), xs2, model(2 * p + 1));
      end
      src.rs1 = 5'd1;
      src.rs2 = 5'd31;
      #1;
      check("x1_abs", xs1, 32'h0000_2000);
      check("x31_abs", xs2, 32'h0002_0000);

      // Test 3: x0 ignores writes.
      @(negedge clk);
      enable     = 1'b1;
      dst.has_rd = 1'b1;
      dst.rd     = 5'd0;
      xd         = 32'hFFFF_FFFF;
      @(negedge clk);
      enable  = 1'b0;
      src.rs1 = 5'd0;
      src.rs2 = 5'd0;
      #1;
      check("x0_w_xs1", xs1, 32'd0);
      check("x0_w_xs2", xs2, 32'd0);

      // Test 4: enable low, then has_rd low; x7 must hold.
      src.rs1 = 5'd7;
      dst.rd  = 5'd7;
      xd      = 32'hDEAD_BEEF;
      @(negedge clk);
      enable     = 1'b0;
      dst.has_rd = 1'b1;
      @(negedge clk);
      #1;
      check("x7_en0", xs1, 32'h0000_8000);
      enable     = 1'b1;
      dst.has_rd = 1'b0;
      @(negedge clk);
      enable = 1'b0;
      #1;
      check("x7_hasrd0", xs1, 32'h0000_8000);

      // Test 5: read-during-write returns old value until the edge.
      @(negedge clk);
      src.rs1    = 5'd9;
      src.rs2    = 5'd9;
      dst.rd     = 5'd9;
      dst.has_rd = 1'b1;
      xd         = 32'h1234_5678;
      enable     = 1'b1;
      #1;
      check("rdw_old_xs1", xs1, 32'h0000_A000);
      check("rdw_old_xs2", xs2, 32'h0000_A000);
      @(posedge clk);
      #1;
      check("rdw_new_xs1", xs1, 32'h1234_5678);
      check("rdw_new_xs2", xs2, 32'h1234_5678);
      enable = 1'b0;
      src.rs1 = 5'd31;
      src.rs2 = 5'd2;
      #1;
      check("pre_arst_x31", xs1, 32'h0002_0000);

      // Test 6: async reset mid-cycle clears everything at once.
      @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      check("arst_x31", xs1, 32'd0);
      check("arst_x2", xs2, 32'd0);
      for (int k = 0; k < 32; k++) begin
         src.rs1 = 5'(k);
         src.rs2 = 5'(31 - k);
         #1;
         check($sformatf("arst_xs1_%0d", k), xs1, 32'd0);
         check($sformatf("arst_xs2_%0d", k), xs2, 32'd0);
      end
      @(negedge clk);
      reset = 1'b1;
      src.rs1 = 5'd9;
      #1;
      check("after_arst_x9", xs1, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
